// File: rtl/operand_bypass_latch.sv
// ID/EX latch with operand bypass and load-use interlock.
// Ports: CLK/nRST clock and sync active-low reset; ID_* decode slot
// inputs; EX_/MEM_* hazard-unit forward sources; freeze/flush
// pipeline control; EX_* registered outputs; stall_id combinational
// PC/IF-ID hold; bubble_count saturating load-use bubble counter.
module operand_bypass_latch (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [31:0] ID_instruction,
    input  logic        ID_valid,
    input  logic [31:0] ID_rdat1,
    input  logic [31:0] ID_rdat2,
    input  logic [4:0]  EX_reg,
    input  logic [4:0]  MEM_reg,
    input  logic        EX_forward,
    input  logic        MEM_forward,
    input  logic        EX_is_load,
    input  logic [31:0] EX_result,
    input  logic [31:0] MEM_result,
    input  logic        freeze,
    input  logic        flush,
    output logic [31:0] EX_instruction_out,
    output logic        EX_valid,
    output logic [31:0] EX_opA,
    output logic [31:0] EX_opB,
    output logic        stall_id,
    output logic [15:0] bubble_count
);

    typedef enum logic {RUN, LU_STALL} state_e;

    state_e      state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic [31:0] opa_q, opa_d;
    logic [31:0] opb_q, opb_d;
    logic [15:0] cnt_q, cnt_d;

    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        use_rs;
    logic        use_rt;
    logic        hz;
    logic        hz_run;
    logic [31:0] byp_a;
    logic [31:0] byp_b;

    assign opcode = ID_instruction[31:26];
    assign rs     = ID_instruction[25:21];
    assign rt     = ID_instruction[20:16];

    assign use_rs = !(opcode == 6'h02 || opcode == 6'h03 ||
                      opcode == 6'h0F);
    assign use_rt = (opcode == 6'h00 || opcode == 6'h04 ||
                     opcode == 6'h05 || opcode == 6'h2B);

    // A load in EX cannot forward yet; its value only exists from MEM.
    function automatic logic [31:0] bypass(
        input logic [4:0]  r,
        input logic [31:0] d,
        input logic        used
    );
        logic [31:0] v;
        v = d;
        if (used && r != 5'd0) begin
            if (EX_forward && EX_reg == r && !EX_is_load)
                v = EX_result;
            else if (MEM_forward && MEM_reg == r)
                v = MEM_result;
        end
        return v;
    endfunction

    assign byp_a = bypass(rs, ID_rdat1, use_rs);
    assign byp_b = bypass(rt, ID_rdat2, use_rt);

    assign hz = ID_valid && EX_forward && EX_is_load &&
                EX_reg != 5'd0 &&
                ((use_rs && EX_reg == rs) ||
                 (use_rt && EX_reg == rt));

    // In LU_STALL the EX slot holds our own bubble, so any
    // apparent hazard there is spurious and ignored.
    assign hz_run   = hz && (state_q == RUN);
    assign stall_id = hz_run && !flush;

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        valid_d = valid_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        cnt_d   = cnt_q;
        if (freeze) begin
            state_d = state_q;
        end else if (flush) begin
            state_d = RUN;
            instr_d = '0;
            valid_d = 1'b0;
            opa_d   = '0;
            opb_d   = '0;
        end else if (hz_run) begin
            state_d = LU_STALL;
            instr_d = '0;
            valid_d = 1'b0;
            opa_d   = '0;
            opb_d   = '0;
            if (cnt_q != 16'hFFFF)
                cnt_d = cnt_q + 16'd1;
        end else if (ID_valid) begin
            state_d = RUN;
            instr_d = ID_instruction;
            valid_d = 1'b1;
            opa_d   = byp_a;
            opb_d   = byp_b;
        end else begin
            state_d = RUN;
            instr_d = '0;
            valid_d = 1'b0;
            opa_d   = '0;
            opb_d   = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= RUN;
            instr_q <= '0;
            valid_q <= 1'b0;
            opa_q   <= '0;
            opb_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            cnt_q   <= cnt_d;
        end
    end

    assign EX_instruction_out = instr_q;
    assign EX_valid           = valid_q;
    assign EX_opA             = opa_q;
    assign EX_opB             = opb_q;
    assign bubble_count       = cnt_q;

endmodule
